// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - register-file writeback stage: load/ALU merge, ALU result FIFO, pending-load scoreboard
// Loads always win the single write port; ALU results wait in the FIFO until a load-free cycle.
module wb_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [0:4]  ex_waddr,
  input  logic [0:63] ex_wdata,
  input  logic [0:2]  ex_ppp,
  input  logic        ld_valid,
  input  logic [0:4]  ld_waddr,
  input  logic [0:63] ld_wdata,
  input  logic [0:2]  ld_ppp,
  input  logic        ld_issue,
  input  logic [0:4]  ld_issue_addr,
  output logic        wrEn,
  output logic [0:4]  waddr,
  output logic [0:63] wdata,
  output logic [0:2]  ppp,
  output logic [0:31] pending,
  output logic        sb_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [0:4]    fifo_addr [FIFO_DEPTH];
  logic [0:63]   fifo_data [FIFO_DEPTH];
  logic [0:2]    fifo_ppp  [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [0:31]   pending_next;
  logic          sb_err_set;

  // ex_ready looks only at the registered count, so a same-cycle pop never opens the door early.
  assign ex_ready = (count != CW'(FIFO_DEPTH));
  assign push     = ex_valid && ex_ready && (ex_waddr != '0);
  assign pop      = !ld_valid && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ex_waddr;
      fifo_data[wr_ptr] <= ex_wdata;
      fifo_ppp[wr_ptr]  <= ex_ppp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrEn  <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      ppp   <= '0;
    end else if (ld_valid) begin
      wrEn  <= (ld_waddr != '0);
      waddr <= ld_waddr;
      wdata <= ld_wdata;
      ppp   <= ld_ppp;
    end else if (pop) begin
      wrEn  <= 1'b1;
      waddr <= fifo_addr[rd_ptr];
      wdata <= fifo_data[rd_ptr];
      ppp   <= fifo_ppp[rd_ptr];
    end else begin
      wrEn  <= 1'b0;
    end
  end

  // Set is applied after clear so a same-cycle issue to the responding register keeps it pending.
  always_comb begin
    pending_next = pending;
    if (ld_valid) pending_next[ld_waddr] = 1'b0;
    if (ld_issue && (ld_issue_addr != '0)) pending_next[ld_issue_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  assign sb_err_set = ld_valid && (ld_waddr != '0) && !pending[ld_waddr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      sb_err  <= 1'b0;
    end else begin
      pending <= pending_next;
      if (sb_err_set) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage
// Expected register-file writes are queued by the stimulus and popped by a negedge monitor.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [0:4]  ex_waddr;
  logic [0:63] ex_wdata;
  logic [0:2]  ex_ppp;
  logic        ld_valid;
  logic [0:4]  ld_waddr;
  logic [0:63] ld_wdata;
  logic [0:2]  ld_ppp;
  logic        ld_issue;
  logic [0:4]  ld_issue_addr;
  logic        wrEn;
  logic [0:4]  waddr;
  logic [0:63] wdata;
  logic [0:2]  ppp;
  logic [0:31] pending;
  logic        sb_err;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
    logic [2:0]  p;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  wb_stage #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_ppp(ex_ppp),
    .ld_valid(ld_valid), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata), .ld_ppp(ld_ppp),
    .ld_issue(ld_issue), .ld_issue_addr(ld_issue_addr),
    .wrEn(wrEn), .waddr(waddr), .wdata(wdata), .ppp(ppp),
    .pending(pending), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [63:0] d, input logic [2:0] p);
    wr_t e;
    e.a = a;
    e.d = d;
    e.p = p;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && wrEn) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got waddr %0d wdata %0h, expected no write", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("mon_waddr", 64'(waddr), 64'(e.a));
        chk("mon_wdata", wdata, e.d);
        chk("mon_ppp", 64'(ppp), 64'(e.p));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  logic        rdy_s;
  logic        exp_rdy [6];
  logic [4:0]  alu_a [3];
  logic [63:0] alu_d [3];
  logic [2:0]  alu_p [3];

  initial begin
    int idx;
    reset = 1'b1;
    ex_valid = 0; ex_waddr = '0; ex_wdata = '0; ex_ppp = '0;
    ld_valid = 0; ld_waddr = '0; ld_wdata = '0; ld_ppp = '0;
    ld_issue = 0; ld_issue_addr = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_wrEn", 64'(wrEn), 0);
    chk("rst_waddr", 64'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ppp", 64'(ppp), 0);
    chk("rst_ex_ready", 64'(ex_ready), 1);
    chk("rst_pending", 64'(pending), 0);
    chk("rst_sb_err", 64'(sb_err), 0);

    // single ALU write
    @(posedge clk); #1;
    ex_valid = 1; ex_waddr = 5'd3; ex_wdata = 64'h1122334455667788; ex_ppp = 3'b001;
    push_exp(5'd3, 64'h1122334455667788, 3'b001);
    @(posedge clk); #1 ex_valid = 0;
    @(negedge clk); chk("alu_e0_wrEn", 64'(wrEn), 0);
    @(negedge clk); chk("alu_e1_wrEn", 64'(wrEn), 1);
    @(negedge clk); chk("alu_e2_wrEn", 64'(wrEn), 0);

    // issue loads to r10..r13 so their responses are legitimate
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ld_issue = 1; ld_issue_addr = 5'(10 + i);
    end
    @(posedge clk); #1 ld_issue = 0;
    @(negedge clk); chk("pend_issue_10_13", 64'(pending[10:13]), 64'hF);

    // load priority and backpressure
    alu_a[0] = 5'd1; alu_d[0] = 64'h00000000000000B1; alu_p[0] = 3'b010;
    alu_a[1] = 5'd2; alu_d[1] = 64'h00000000000000B2; alu_p[1] = 3'b011;
    alu_a[2] = 5'd3; alu_d[2] = 64'h00000000000000B3; alu_p[2] = 3'b100;
    exp_rdy[0] = 1; exp_rdy[1] = 1; exp_rdy[2] = 0; exp_rdy[3] = 0; exp_rdy[4] = 0; exp_rdy[5] = 1;
    for (int k = 0; k < 4; k++) push_exp(5'(10 + k), 64'hA0 + 64'(k), 3'(k));
    for (int k = 0; k < 3; k++) push_exp(alu_a[k], alu_d[k], alu_p[k]);
    @(posedge clk); #1;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      ld_valid = (k < 4);
      ld_waddr = 5'(10 + k);
      ld_wdata = 64'hA0 + 64'(k);
      ld_ppp   = 3'(k);
      ex_valid = (idx < 3);
      if (idx < 3) begin
        ex_waddr = alu_a[idx]; ex_wdata = alu_d[idx]; ex_ppp = alu_p[idx];
      end
      @(negedge clk);
      rdy_s = ex_ready;
      if (k < 6) chk($sformatf("bp_ex_ready_%0d", k), 64'(ex_ready), 64'(exp_rdy[k]));
      @(posedge clk);
      if (ex_valid && rdy_s) idx++;
      #1;
    end
    ex_valid = 0; ld_valid = 0;
    @(negedge clk);
    chk("bp_pend_cleared", 64'(pending[10:13]), 0);
    chk("bp_sb_err", 64'(sb_err), 0);

    // register 0: ALU result and load to r0, issue to r0
    @(posedge clk); #1;
    ex_valid = 1; ex_waddr = 5'd0; ex_wdata = 64'hFFFF; ex_ppp = 3'b000;
    ld_issue = 1; ld_issue_addr = 5'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk($sformatf("r0_ex_ready_%0d", k), 64'(ex_ready), 1);
      @(posedge clk); #1;
    end
    ex_valid = 0; ld_issue = 0;
    @(negedge clk); chk("r0_alu_no_write", 64'(wrEn), 0);
    @(posedge clk); #1;
    ld_valid = 1; ld_waddr = 5'd0; ld_wdata = 64'h1234; ld_ppp = 3'b000;
    @(posedge clk); #1 ld_valid = 0;
    @(negedge clk);
    chk("r0_ld_wrEn", 64'(wrEn), 0);
    chk("r0_ld_sb_err", 64'(sb_err), 0);
    chk("r0_pending0", 64'(pending[0]), 0);

    // scoreboard on r7
    @(posedge clk); #1;
    ld_issue = 1; ld_issue_addr = 5'd7;
    @(posedge clk); #1 ld_issue = 0;
    @(negedge clk); chk("sb_issue_p7", 64'(pending[7]), 1);
    @(posedge clk); #1;
    ld_issue = 1; ld_issue_addr = 5'd7;
    ld_valid = 1; ld_waddr = 5'd7; ld_wdata = 64'hC1; ld_ppp = 3'b001;
    push_exp(5'd7, 64'hC1, 3'b001);
    @(posedge clk); #1 ld_issue = 0; ld_valid = 0;
    @(negedge clk);
    chk("sb_setwins_p7", 64'(pending[7]), 1);
    chk("sb_setwins_err", 64'(sb_err), 0);
    @(posedge clk); #1;
    ld_valid = 1; ld_waddr = 5'd7; ld_wdata = 64'hC2; ld_ppp = 3'b010;
    push_exp(5'd7, 64'hC2, 3'b010);
    @(posedge clk); #1 ld_valid = 0;
    @(negedge clk);
    chk("sb_clear_p7", 64'(pending[7]), 0);
    chk("sb_clear_err", 64'(sb_err), 0);
    @(posedge clk); #1;
    ld_valid = 1; ld_waddr = 5'd7; ld_wdata = 64'hC3; ld_ppp = 3'b011;
    push_exp(5'd7, 64'hC3, 3'b011);
    @(posedge clk); #1 ld_valid = 0;
    @(negedge clk); chk("sb_err_set", 64'(sb_err), 1);
    @(negedge clk); chk("sb_err_sticky", 64'(sb_err), 1);

    // asynchronous reset with two entries queued and r5 pending
    @(posedge clk); #1;
    ld_issue = 1; ld_issue_addr = 5'd5;
    ld_valid = 1; ld_waddr = 5'd0; ld_wdata = 64'hDEAD; ld_ppp = 3'b100;
    ex_valid = 1; ex_waddr = 5'd20; ex_wdata = 64'hE20; ex_ppp = 3'b001;
    @(posedge clk); #1;
    ld_issue = 0; ex_waddr = 5'd21; ex_wdata = 64'hE21;
    @(posedge clk); #1 ex_valid = 0;
    @(negedge clk);
    chk("pre_rst_ex_ready", 64'(ex_ready), 0);
    chk("pre_rst_p5", 64'(pending[5]), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_wrEn", 64'(wrEn), 0);
    chk("arst_waddr", 64'(waddr), 0);
    chk("arst_wdata", wdata, 0);
    chk("arst_ppp", 64'(ppp), 0);
    chk("arst_ex_ready", 64'(ex_ready), 1);
    chk("arst_pending", 64'(pending), 0);
    chk("arst_sb_err", 64'(sb_err), 0);
    @(posedge clk); #1;
    reset = 1'b0; ld_valid = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_wrEn", 64'(wrEn), 0);
    chk("exp_q_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
